// File: rtl/daq_pkt_pkg.sv
// Shared definitions for the DAQ byte-packet link (packetizer and depacketizer).
package daq_pkt_pkg;
   localparam logic [31:0] HDR_SIG  = 32'h30415144;
   localparam logic [7:0]  END_BYTE = 8'h00;

   // Bit positions inside pkt_status
   localparam int STAT_HDR_ERR = 0;
   localparam int STAT_END_ERR = 1;
   localparam int STAT_LEN_ERR = 2;

   typedef enum logic [3:0] {
      ST_HUNT,
      ST_HDR,
      ST_TS,
      ST_CHN,
      ST_CNT,
      ST_PAY,
      ST_ERR,
      ST_END,
      ST_DROP
   } rx_state_e;
endpackage

// File: rtl/pkt_byte_assembler.sv
// Packs payload bytes LSB first into a sample word and holds it in a single
// valid/ready output register.
module pkt_byte_assembler #(
   parameter int DATA_W = 32,
   parameter int USER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,       // payload byte accepted this cycle
   input  logic [7:0]        in_data,
   input  logic [USER_W-1:0] in_user,
   input  logic              in_word_last, // word completed by this byte ends the packet
   input  logic              flush,        // packet cut short: drop partial, mark pending word last
   output logic              in_rdy,       // output register can take a word this cycle
   output logic              last_byte,    // next byte completes a word
   output logic [DATA_W-1:0] m_tdata,
   output logic [USER_W-1:0] m_tuser,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast
);
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-9:0] sh_q,  sh_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [USER_W-1:0] usr_q, usr_d;
   logic              lst_q, lst_d;
   logic              vld_q, vld_d;

   assign in_rdy    = !vld_q || m_tready;
   assign last_byte = (idx_q == 2'd3);
   assign m_tdata   = dat_q;
   assign m_tuser   = usr_q;
   assign m_tvalid  = vld_q;
   assign m_tlast   = lst_q;

   // Byte packing, output load/drain, and tlast forcing on a stalled word
   always_comb begin
      idx_d = idx_q;
      sh_d  = sh_q;
      dat_d = dat_q;
      usr_d = usr_q;
      lst_d = lst_q;
      vld_d = vld_q;
      if (vld_q && m_tready) vld_d = 1'b0;
      if (flush) begin
         idx_d = 2'd0;
         // A word still waiting downstream becomes the packet's final beat.
         if (vld_q && !m_tready) lst_d = 1'b1;
      end else if (in_vld) begin
         if (idx_q == 2'd3) begin
            dat_d = {in_data, sh_q};
            usr_d = in_user;
            lst_d = in_word_last;
            vld_d = 1'b1;
            idx_d = 2'd0;
         end else begin
            sh_d[8*idx_q +: 8] = in_data;
            idx_d = idx_q + 2'd1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         sh_q  <= '0;
         dat_q <= '0;
         usr_q <= '0;
         lst_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         sh_q  <= sh_d;
         dat_q <= dat_d;
         usr_q <= usr_d;
         lst_q <= lst_d;
         vld_q <= vld_d;
      end
   end
endmodule

// File: rtl/axi_depacketizer.sv
// Receive-side DAQ packet parser: byte stream in, 32-bit samples plus
// per-packet header fields and status out.
module axi_depacketizer
   import daq_pkt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int USER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_axi_tdata,
   input  logic              s_axi_tvalid,
   output logic              s_axi_tready,
   input  logic              s_axi_tlast,
   output logic [DATA_W-1:0] m_axi_tdata,
   output logic [USER_W-1:0] m_axi_tuser,
   output logic              m_axi_tvalid,
   input  logic              m_axi_tready,
   output logic              m_axi_tlast,
   output logic [31:0]       pkt_timestamp,
   output logic [7:0]        pkt_channel,
   output logic [7:0]        pkt_count,
   output logic [15:0]       pkt_error_flags,
   output logic              pkt_done,
   output logic [2:0]        pkt_status
);
   rx_state_e   state_q, state_d;
   logic [1:0]  idx_q,   idx_d;
   logic [31:0] ts_sh_q, ts_sh_d;
   logic [7:0]  chn_sh_q, chn_sh_d;
   logic [15:0] err_sh_q, err_sh_d;
   logic [8:0]  smp_q,   smp_d;
   logic        lost_q,  lost_d;   // inside a lost-sync episode
   logic        run_q;             // holds tready low until out of reset
   logic [31:0] ts_q,    ts_d;
   logic [7:0]  chn_q,   chn_d;
   logic [7:0]  cnt_q,   cnt_d;
   logic [15:0] ef_q,    ef_d;
   logic        done_q,  done_d;
   logic [2:0]  stat_q,  stat_d;

   logic        acc, asm_vld, asm_last, asm_flush, asm_rdy, asm_idx3;
   logic [8:0]  total;

   assign total = {cnt_q == 8'd0, cnt_q};
   // In PAY only the word-completing byte needs room downstream; bytes 0..2
   // just go into the packer, so they never wait on m_tready.
   assign s_axi_tready = run_q && (state_q != ST_PAY || asm_rdy || !asm_idx3);
   assign acc          = s_axi_tvalid && s_axi_tready;

   assign pkt_timestamp   = ts_q;
   assign pkt_channel     = chn_q;
   assign pkt_count       = cnt_q;
   assign pkt_error_flags = ef_q;
   assign pkt_done        = done_q;
   assign pkt_status      = stat_q;

   pkt_byte_assembler #(.DATA_W(DATA_W), .USER_W(USER_W)) u_asm (
      .clk          (clk),
      .rst          (rst),
      .in_vld       (asm_vld),
      .in_data      (s_axi_tdata),
      .in_user      ({{(USER_W-4){1'b0}}, chn_q[3:0]}),
      .in_word_last (asm_last),
      .flush        (asm_flush),
      .in_rdy       (asm_rdy),
      .last_byte    (asm_idx3),
      .m_tdata      (m_axi_tdata),
      .m_tuser      (m_axi_tuser),
      .m_tvalid     (m_axi_tvalid),
      .m_tready     (m_axi_tready),
      .m_tlast      (m_axi_tlast)
   );

   // Parser FSM: next state, field capture and status generation
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ts_sh_d   = ts_sh_q;
      chn_sh_d  = chn_sh_q;
      err_sh_d  = err_sh_q;
      smp_d     = smp_q;
      lost_d    = lost_q;
      ts_d      = ts_q;
      chn_d     = chn_q;
      cnt_d     = cnt_q;
      ef_d      = ef_q;
      done_d    = 1'b0;
      stat_d    = stat_q;
      asm_vld   = 1'b0;
      asm_last  = 1'b0;
      asm_flush = 1'b0;
      if (acc) begin
         if (s_axi_tlast && state_q != ST_HUNT && state_q != ST_END && state_q != ST_DROP) begin
            // Packet ended early
            done_d               = 1'b1;
            stat_d               = '0;
            stat_d[STAT_LEN_ERR] = 1'b1;
            state_d              = ST_HUNT;
            idx_d                = 2'd0;
            asm_flush            = (state_q == ST_PAY);
         end else begin
            case (state_q)
               ST_HUNT: begin
                  if (!s_axi_tlast && s_axi_tdata == HDR_SIG[7:0]) begin
                     state_d = ST_HDR;
                     idx_d   = 2'd1;
                  end
               end
               ST_HDR: begin
                  if (s_axi_tdata == HDR_SIG[8*idx_q +: 8]) begin
                     idx_d = idx_q + 2'd1;
                     if (idx_q == 2'd3) begin
                        state_d = ST_TS;
                        lost_d  = 1'b0;
                     end
                  end else begin
                     if (!lost_q) begin
                        done_d               = 1'b1;
                        stat_d               = '0;
                        stat_d[STAT_HDR_ERR] = 1'b1;
                     end
                     lost_d = 1'b1;
                     // The offending byte may itself start a new header.
                     if (s_axi_tdata == HDR_SIG[7:0]) begin
                        idx_d = 2'd1;
                     end else begin
                        state_d = ST_HUNT;
                        idx_d   = 2'd0;
                     end
                  end
               end
               ST_TS: begin
                  ts_sh_d[8*idx_q +: 8] = s_axi_tdata;
                  idx_d                 = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = ST_CHN;
               end
               ST_CHN: begin
                  chn_sh_d = s_axi_tdata;
                  state_d  = ST_CNT;
               end
               ST_CNT: begin
                  ts_d    = ts_sh_q;
                  chn_d   = chn_sh_q;
                  cnt_d   = s_axi_tdata;
                  smp_d   = 9'd0;
                  state_d = ST_PAY;
               end
               ST_PAY: begin
                  asm_vld = 1'b1;
                  if (asm_idx3) begin
                     smp_d    = smp_q + 9'd1;
                     asm_last = (smp_q + 9'd1 == total);
                     if (asm_last) begin
                        state_d = ST_ERR;
                        idx_d   = 2'd0;
                     end
                  end
               end
               ST_ERR: begin
                  if (idx_q == 2'd0) err_sh_d[7:0]  = s_axi_tdata;
                  if (idx_q == 2'd1) err_sh_d[15:8] = s_axi_tdata;
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = ST_END;
               end
               ST_END: begin
                  ef_d = err_sh_q;
                  if (s_axi_tlast) begin
                     done_d               = 1'b1;
                     stat_d               = '0;
                     stat_d[STAT_END_ERR] = (s_axi_tdata != END_BYTE);
                     state_d              = ST_HUNT;
                  end else begin
                     stat_d               = '0;
                     stat_d[STAT_LEN_ERR] = 1'b1;
                     state_d              = ST_DROP;
                  end
               end
               ST_DROP: begin
                  if (s_axi_tlast) begin
                     done_d               = 1'b1;
                     stat_d               = '0;
                     stat_d[STAT_LEN_ERR] = 1'b1;
                     state_d              = ST_HUNT;
                  end
               end
               default: state_d = ST_HUNT;
            endcase
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_HUNT;
         idx_q    <= '0;
         ts_sh_q  <= '0;
         chn_sh_q <= '0;
         err_sh_q <= '0;
         smp_q    <= '0;
         lost_q   <= 1'b0;
         run_q    <= 1'b0;
         ts_q     <= '0;
         chn_q    <= '0;
         cnt_q    <= '0;
         ef_q     <= '0;
         done_q   <= 1'b0;
         stat_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ts_sh_q  <= ts_sh_d;
         chn_sh_q <= chn_sh_d;
         err_sh_q <= err_sh_d;
         smp_q    <= smp_d;
         lost_q   <= lost_d;
         run_q    <= 1'b1;
         ts_q     <= ts_d;
         chn_q    <= chn_d;
         cnt_q    <= cnt_d;
         ef_q     <= ef_d;
         done_q   <= done_d;
         stat_q   <= stat_d;
      end
   end
endmodule

// File: tb/tb_axi_depacketizer.sv
// Scoreboard bench for axi_depacketizer: stimulus pushes expected beats and
// status events, an independent monitor pops and compares them.
module tb_axi_depacketizer;
   logic        clk, rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [31:0] m_tdata;
   logic [7:0]  m_tuser;
   logic        m_tvalid, m_tready, m_tlast;
   logic [31:0] pkt_timestamp;
   logic [7:0]  pkt_channel, pkt_count;
   logic [15:0] pkt_error_flags;
   logic        pkt_done;
   logic [2:0]  pkt_status;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  u;
      logic        l;
   } beat_t;
   typedef struct {
      logic [2:0]  st;
      bit          fld;
      logic [31:0] ts;
      logic [7:0]  chn;
      logic [7:0]  cnt;
      logic [15:0] ef;
   } stat_t;

   beat_t       bq[$];
   stat_t       sq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mode  = 0;   // m_tready: 0 always, 1 one-in-three, 2 held low
   bit          rdy_chk = 0;
   logic [31:0] pay[256];

   axi_depacketizer #(.DATA_W(32), .USER_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .s_axi_tdata     (s_tdata),
      .s_axi_tvalid    (s_tvalid),
      .s_axi_tready    (s_tready),
      .s_axi_tlast     (s_tlast),
      .m_axi_tdata     (m_tdata),
      .m_axi_tuser     (m_tuser),
      .m_axi_tvalid    (m_tvalid),
      .m_axi_tready    (m_tready),
      .m_axi_tlast     (m_tlast),
      .pkt_timestamp   (pkt_timestamp),
      .pkt_channel     (pkt_channel),
      .pkt_count       (pkt_count),
      .pkt_error_flags (pkt_error_flags),
      .pkt_done        (pkt_done),
      .pkt_status      (pkt_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // Downstream ready pattern
   initial begin
      int cyc = 0;
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 3 == 0);
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Monitor: compare every transfer and every status pulse with the queues
   initial begin
      beat_t b;
      stat_t s;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (m_tvalid && m_tready) begin
               if (bq.size() == 0) begin
                  chk("beat_unexpected", {32'h0, m_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  b = bq.pop_front();
                  chk("beat_data", m_tdata, b.d);
                  chk("beat_user", m_tuser, b.u);
                  chk("beat_last", m_tlast, b.l);
               end
            end
            if (pkt_done) begin
               if (sq.size() == 0) begin
                  chk("done_unexpected", pkt_status, 64'hFF);
               end else begin
                  s = sq.pop_front();
                  chk("pkt_status", pkt_status, s.st);
                  if (s.fld) begin
                     chk("pkt_timestamp", pkt_timestamp, s.ts);
                     chk("pkt_channel", pkt_channel, s.chn);
                     chk("pkt_count", pkt_count, s.cnt);
                     chk("pkt_error_flags", pkt_error_flags, s.ef);
                  end
               end
            end
            if (rdy_chk && s_tvalid && !s_tready)
               chk("s_tready_low_without_stall", m_tvalid && !m_tready, 1);
         end
      end
   end

   // Present one byte starting at a negedge; returns at the negedge after acceptance
   task automatic send_byte(input logic [7:0] d, input logic l);
      int  n = 0;
      bit  a;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      forever begin
         #1;
         a = s_tready;
         @(posedge clk);
         @(negedge clk);
         if (a) break;
         n++;
         if (n > 500) begin
            timeout("s_tready");
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_head(input logic [31:0] ts, input logic [7:0] chn, input logic [7:0] cnt);
      send_byte(8'h44, 0); send_byte(8'h51, 0); send_byte(8'h41, 0); send_byte(8'h30, 0);
      send_byte(ts[7:0], 0); send_byte(ts[15:8], 0); send_byte(ts[23:16], 0); send_byte(ts[31:24], 0);
      send_byte(chn, 0);
      send_byte(cnt, 0);
   endtask

   // Well-formed packet using pay[]; expectations are queued before sending
   task automatic send_pkt(input logic [31:0] ts, input logic [7:0] chn, input logic [7:0] cnt,
                           input logic [15:0] ef);
      int    ns;
      beat_t b;
      stat_t s;
      ns = (cnt == 8'd0) ? 256 : int'(cnt);
      for (int i = 0; i < ns; i++) begin
         b.d = pay[i];
         b.u = {4'h0, chn[3:0]};
         b.l = (i == ns - 1);
         bq.push_back(b);
      end
      s.st = 3'b000; s.fld = 1'b1; s.ts = ts; s.chn = chn; s.cnt = cnt; s.ef = ef;
      sq.push_back(s);
      send_head(ts, chn, cnt);
      for (int i = 0; i < ns; i++)
         for (int k = 0; k < 4; k++)
            send_byte(pay[i][8*k +: 8], 0);
      send_byte(ef[7:0], 0);
      send_byte(ef[15:8], 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((bq.size() != 0 || sq.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (bq.size() != 0 || sq.size() != 0) begin
         timeout(name);
         bq.delete();
         sq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      beat_t b;
      stat_t s;
      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;

      // Reset state
      #13;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_pkt_status", pkt_status, 0);
      chk("rst_pkt_timestamp", pkt_timestamp, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: basic two-sample packet
      pay[0] = 32'hA0A1A2A3;
      pay[1] = 32'hB0B1B2B3;
      send_pkt(32'h11223344, 8'h03, 8'h02, 16'h0005);
      drain("t1_drain");

      // 2: same packet under 1/3 downstream duty
      mode = 1; rdy_chk = 1;
      send_pkt(32'h11223344, 8'h03, 8'h02, 16'h0005);
      drain("t2_drain");
      rdy_chk = 0; mode = 0;

      // 3: partial header garbage then a valid packet
      s.st = 3'b001; s.fld = 1'b0; s.ts = '0; s.chn = '0; s.cnt = '0; s.ef = '0;
      sq.push_back(s);
      send_byte(8'h44, 0); send_byte(8'h51, 0); send_byte(8'h00, 0);
      send_pkt(32'hCAFEF00D, 8'h17, 8'h02, 16'h0005);
      drain("t3_drain");

      // 4: tlast on 5th payload byte while the first word is still pending
      mode = 2;
      b.d = 32'h44332211; b.u = 8'h05; b.l = 1'b1;
      bq.push_back(b);
      s.st = 3'b100; s.fld = 1'b1; s.ts = 32'h01020304; s.chn = 8'h05; s.cnt = 8'h02; s.ef = 16'h0005;
      sq.push_back(s);
      send_head(32'h01020304, 8'h05, 8'h02);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      send_byte(8'h55, 1);
      repeat (3) @(negedge clk);
      mode = 0;
      drain("t4_drain");

      // 5: count 0 means 256 samples
      for (int i = 0; i < 256; i++) pay[i] = {8'(i), 8'h5A, 8'(255 - i), 8'(i ^ 8'h3C)};
      send_pkt(32'hDEADBEEF, 8'h02, 8'h00, 16'hA55A);
      drain("t5_drain");

      // 6: asynchronous reset in mid-payload, then a clean packet
      mode = 2;
      send_head(32'h99887766, 8'h01, 8'h04);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(8'h05, 0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_m_tvalid", m_tvalid, 0);
      chk("arst_s_tready", s_tready, 0);
      chk("arst_pkt_timestamp", pkt_timestamp, 0);
      chk("arst_pkt_channel", pkt_channel, 0);
      chk("arst_pkt_count", pkt_count, 0);
      chk("arst_pkt_error_flags", pkt_error_flags, 0);
      chk("arst_pkt_done", pkt_done, 0);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      mode = 0;
      @(negedge clk);
      pay[0] = 32'hA0A1A2A3;
      pay[1] = 32'hB0B1B2B3;
      send_pkt(32'h0BADCAFE, 8'h0C, 8'h02, 16'h1234);
      drain("t6_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
